reu_dma_seq: RTL and testbench
==============================

# reu_dma_seq

REU transfer sequencer that sits directly downstream of the REU register file. It consumes `Execute`, `XferType` and `Length1`, and takes ownership of the C64 bus via DMA. It moves bytes between C64 memory and REU SRAM for stash, fetch, swap and verify transfers. It returns `NextCA`, `NextREUA`, `VerifyErr` and `XferEnd` so the register file can advance addresses and the length, and can post status.

## Interface
Parameters:
- `START_WAIT`, default 1: number of idle DMA cycles between asserting `DMA` and the first bus access (CPU release), range 1–3.

Ports:
- `PHI2` in 1: system clock; all state updates on the falling edge.
- `Reset` in 1: asynchronous, active-high; forces IDLE.
- `Execute` in 1: start request from the register file, sampled at the falling edge.
- `XferType` in 2: 00 stash (C64→REU), 01 fetch (REU→C64), 10 swap, 11 verify.
- `Length1` in 1: high when the current byte is the last one.
- `BA` in 1: bus available; low stalls the transfer.
- `CDIn` in 8: C64 data bus input.
- `RAMDIn` in 8: REU SRAM read data.
- `DMA` out 1: C64 DMA request (active high, inverted externally).
- `CRW` out 1: C64 bus direction, 1 = read.
- `CDOut` in/out: `CDOut` out 8 is C64 write data; `CDOE` out 1 is the C64 data drive enable.
- `RAMDOut` out 8: SRAM write data. `RAMWE` out 1: SRAM write strobe.
- `NextCA` out 1: one-cycle pulse per completed byte; also decrements `Length` in the register file.
- `NextREUA` out 1: one-cycle pulse per completed byte.
- `VerifyErr` out 1: one-cycle pulse on a verify mismatch.
- `XferEnd` out 1: one-cycle pulse at transfer end.
- `Busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, MOVE, SWAPR, SWAPW, END.
- IDLE: all outputs low, except `CRW` = 1.
  - `Execute` = 1 at a falling edge → WAIT with counter = `START_WAIT`.
  - `XferType` is latched into `typ` at the same edge and is held for the whole transfer.
- WAIT: `DMA` = 1.
  - The counter decrements while `BA` = 1.
  - When the counter reaches 0 and `BA` = 1, go to MOVE if `typ` ≠ 10, or to SWAPR if `typ` = 10.
- MOVE, one byte per cycle:
  - Stash: `CRW` = 1, `RAMWE` = 1, `RAMDOut` = `CDIn`.
  - Fetch: `CRW` = 0, `CDOE` = 1, `CDOut` = `RAMDIn` (combinational; the SRAM access fits within the cycle).
  - Verify: `CRW` = 1, no writes; compare `CDIn` with `RAMDIn` at the falling edge.
  - `NextCA` and `NextREUA` = 1 each MOVE cycle in which `BA` = 1.
- SWAPR: `CRW` = 1. Latch `CDIn` → `cbuf` and `RAMDIn` → `rbuf`; then go to SWAPW. No Next pulses.
- SWAPW: `CRW` = 0, `CDOE` = 1, `CDOut` = `rbuf`, `RAMWE` = 1, `RAMDOut` = `cbuf`. Pulse `NextCA` and `NextREUA`.
  - If `Length1` → END, else → SWAPR.
- Termination:
  - In MOVE, a byte completed with `Length1` = 1 → END.
  - A verify mismatch → END with `VerifyErr` = 1 during END. The mismatching byte still pulses Next.
- END: `XferEnd` = 1, `DMA` = 0; → IDLE next edge.
- `BA` = 0 in MOVE, SWAPR or SWAPW: hold state, suppress `RAMWE`, `CDOE` and Next pulses, keep `DMA` = 1. Resume when `BA` returns.
- `Execute` while `Busy`: ignored.

## Timing
- Reset (async): IDLE. Outputs: `DMA` = 0, `CRW` = 1, `CDOE` = 0, `RAMWE` = 0, Next pulses = 0, `VerifyErr` = 0, `XferEnd` = 0, `Busy` = 0, `CDOut` = 0, `RAMDOut` = 0.
- Reset mid-transfer: `DMA` drops immediately; no `XferEnd` is issued.
- All outputs are decoded from registered state and `BA`; none is a function of `Execute`.
- Latency from the `Execute` edge to the first bus access is `START_WAIT` + 1 cycles, with `BA` high.
- Byte rates:
  - Stash, fetch and verify: 1 byte per cycle.
  - Swap: 2 cycles per byte.
  - Total cycles for N bytes, non-swap: 1 + `START_WAIT` + N + 1 (END).
- `Length` = 1 transfers exactly one byte.
- `Length` = 0 means 65536 in the register file; the sequencer just follows `Length1`.
- `XferEnd` and `VerifyErr` are coincident in the same END cycle, so the register file sees one status event.

## Test plan
- Stash, `Length1` asserted on the 3rd byte, `START_WAIT` = 1, `BA` = 1:
  - `Execute` → `DMA` high 1 cycle later.
  - 3 `RAMWE` cycles carrying `CDIn` bytes AA, 55, 0F.
  - 3 `NextCA` and 3 `NextREUA` pulses, then one `XferEnd` pulse.
  - `DMA` low after END; total 6 cycles.
- Fetch of 2 bytes, with `RAMDIn` = 12 then 34 → `CDOE` = 1 and `CRW` = 0 on exactly 2 cycles, `CDOut` = 12 then 34.
- Swap of 1 byte, with C64 = 5A and REU = A5:
  - SWAPR then SWAPW.
  - SWAPW drives `CDOut` = A5 and `RAMDOut` = 5A.
  - One Next pulse pair, then `XferEnd`.
- Verify, 4 bytes, mismatch at byte 2 → 2 Next pulses, then END with `VerifyErr` = 1 and `XferEnd` = 1 in the same cycle; byte 3 is never accessed.
- Stash with `BA` forced low for 3 cycles at byte 2 → no `RAMWE` and no Next during the stall, `DMA` stays 1, and the byte count is unchanged.
- Reset pulsed during MOVE of a fetch → `DMA`, `CDOE` and `Busy` are 0 asynchronously, no `XferEnd`, and a new `Execute` starts cleanly.

Source files
------------

// File: rtl/reu_dma_seq_if.sv
// Bus bundle between the REU register file / C64 bus side and the transfer sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface reu_dma_seq_if;
  logic       Execute;
  logic [1:0] XferType;
  logic       Length1;
  logic       BA;
  logic [7:0] CDIn;
  logic [7:0] RAMDIn;
  logic       DMA;
  logic       CRW;
  logic [7:0] CDOut;
  logic       CDOE;
  logic [7:0] RAMDOut;
  logic       RAMWE;
  logic       NextCA;
  logic       NextREUA;
  logic       VerifyErr;
  logic       XferEnd;
  logic       Busy;

  modport master (
    output Execute, XferType, Length1, BA, CDIn, RAMDIn,
    input  DMA, CRW, CDOut, CDOE, RAMDOut, RAMWE,
    input  NextCA, NextREUA, VerifyErr, XferEnd, Busy
  );

  modport slave (
    input  Execute, XferType, Length1, BA, CDIn, RAMDIn,
    output DMA, CRW, CDOut, CDOE, RAMDOut, RAMWE,
    output NextCA, NextREUA, VerifyErr, XferEnd, Busy
  );
endinterface

// File: rtl/reu_dma_seq.sv
// REU transfer sequencer: owns the C64 bus via DMA and moves bytes for stash,
// fetch, swap and verify. State advances on the falling edge of PHI2.
module reu_dma_seq #(
  parameter int unsigned START_WAIT = 1
) (
  input  logic          PHI2,
  input  logic          Reset,
  reu_dma_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_MOVE  = 3'd2,
    S_SWAPR = 3'd3,
    S_SWAPW = 3'd4,
    S_END   = 3'd5
  } state_t;

  localparam logic [1:0] T_STASH  = 2'b00;
  localparam logic [1:0] T_FETCH  = 2'b01;
  localparam logic [1:0] T_SWAP   = 2'b10;
  localparam logic [1:0] T_VERIFY = 2'b11;
  localparam logic [1:0] C_START  = 2'(START_WAIT);

  function automatic logic f_byte_miss(input logic [7:0] a, input logic [7:0] b);
    return (a != b);
  endfunction

  state_t     r_state;
  logic [1:0] r_typ;
  logic [1:0] r_cnt;
  logic [7:0] r_cbuf;
  logic [7:0] r_rbuf;
  logic       r_verr;
  logic       w_miss;

  assign w_miss = f_byte_miss(bus.CDIn, bus.RAMDIn);

  // Transfer state machine; BA low freezes every bus-owning state.
  always_ff @(negedge PHI2 or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_typ   <= 2'b00;
      r_cnt   <= 2'd0;
      r_cbuf  <= 8'h00;
      r_rbuf  <= 8'h00;
      r_verr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Execute) begin
            r_state <= S_WAIT;
            r_typ   <= bus.XferType;
            r_cnt   <= C_START;
            r_verr  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.BA) begin
            if (r_cnt == 2'd0) begin
              r_state <= (r_typ == T_SWAP) ? S_SWAPR : S_MOVE;
            end else begin
              r_cnt <= r_cnt - 2'd1;
            end
          end
        end
        S_MOVE: begin
          if (bus.BA) begin
            if ((r_typ == T_VERIFY) && w_miss) begin
              r_verr  <= 1'b1;
              r_state <= S_END;
            end else if (bus.Length1) begin
              r_state <= S_END;
            end
          end
        end
        S_SWAPR: begin
          if (bus.BA) begin
            r_cbuf  <= bus.CDIn;
            r_rbuf  <= bus.RAMDIn;
            r_state <= S_SWAPW;
          end
        end
        S_SWAPW: begin
          if (bus.BA) begin
            r_state <= bus.Length1 ? S_END : S_SWAPR;
          end
        end
        S_END: begin
          r_state <= S_IDLE;
          r_verr  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state and BA; fetch data passes straight through.
  always_comb begin
    bus.DMA       = 1'b0;
    bus.CRW       = 1'b1;
    bus.CDOut     = 8'h00;
    bus.CDOE      = 1'b0;
    bus.RAMDOut   = 8'h00;
    bus.RAMWE     = 1'b0;
    bus.NextCA    = 1'b0;
    bus.NextREUA  = 1'b0;
    bus.VerifyErr = 1'b0;
    bus.XferEnd   = 1'b0;
    bus.Busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        bus.DMA = 1'b0;
      end
      S_WAIT: begin
        bus.DMA = 1'b1;
      end
      S_MOVE: begin
        bus.DMA      = 1'b1;
        bus.CRW      = (r_typ != T_FETCH);
        bus.CDOE     = (r_typ == T_FETCH) && bus.BA;
        bus.CDOut    = (r_typ == T_FETCH) ? bus.RAMDIn : 8'h00;
        bus.RAMWE    = (r_typ == T_STASH) && bus.BA;
        bus.RAMDOut  = (r_typ == T_STASH) ? bus.CDIn : 8'h00;
        bus.NextCA   = bus.BA;
        bus.NextREUA = bus.BA;
      end
      S_SWAPR: begin
        bus.DMA = 1'b1;
      end
      S_SWAPW: begin
        bus.DMA      = 1'b1;
        bus.CRW      = 1'b0;
        bus.CDOE     = bus.BA;
        bus.CDOut    = r_rbuf;
        bus.RAMWE    = bus.BA;
        bus.RAMDOut  = r_cbuf;
        bus.NextCA   = bus.BA;
        bus.NextREUA = bus.BA;
      end
      S_END: begin
        bus.XferEnd   = 1'b1;
        bus.VerifyErr = r_verr;
      end
      default: begin
        bus.DMA = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reu_dma_seq.sv
// Scoreboard bench for reu_dma_seq: a small register-file/memory model feeds the
// sequencer, expected bus writes are queued up front and popped as they appear.
module tb_reu_dma_seq;

  logic phi2;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [7:0] c_mem [0:7];
  logic [7:0] r_mem [0:7];
  logic [7:0] q_ram [$];
  logic [7:0] q_cd  [$];

  reu_dma_seq_if bus_if ();

  reu_dma_seq #(.START_WAIT(1)) u_dut (
    .PHI2  (phi2),
    .Reset (reset),
    .bus   (bus_if)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer; stall_at is the byte index held with BA low for stall_n cycles.
  task automatic run_xfer(input logic [1:0] typ, input int len, input int stall_at,
                          input int stall_n, input int exp_bytes, input logic exp_verr,
                          input int exp_cycles);
    int   ca;
    int   rem;
    int   busy_n;
    int   next_n;
    int   end_n;
    int   ram_n;
    int   cd_n;
    int   crw0_n;
    int   exp_ram_n;
    int   exp_cd_n;
    int   stall_left;
    logic ba;
    logic nxt;
    for (int i = 0; i < exp_bytes; i++) begin
      if (typ == 2'b00 || typ == 2'b10) q_ram.push_back(c_mem[i]);
      if (typ == 2'b01 || typ == 2'b10) q_cd.push_back(r_mem[i]);
    end
    exp_ram_n  = q_ram.size();
    exp_cd_n   = q_cd.size();
    ca = 0; rem = len; busy_n = 0; next_n = 0; end_n = 0;
    ram_n = 0; cd_n = 0; crw0_n = 0; stall_left = stall_n;
    @(posedge phi2);
    bus_if.Execute  = 1'b1;
    bus_if.XferType = typ;
    bus_if.BA       = 1'b1;
    bus_if.Length1  = (rem == 1);
    bus_if.CDIn     = c_mem[0];
    bus_if.RAMDIn   = r_mem[0];
    @(negedge phi2);
    for (int iter = 0; iter < 200; iter++) begin
      @(posedge phi2);
      bus_if.Execute = (iter == 3);
      ba             = !((ca == stall_at) && (stall_left > 0));
      bus_if.BA      = ba;
      bus_if.Length1 = (rem == 1);
      bus_if.CDIn    = c_mem[ca % 8];
      bus_if.RAMDIn  = r_mem[ca % 8];
      #2;
      if (!bus_if.Busy) break;
      busy_n++;
      if (iter == 0) chk("dma_start", bus_if.DMA, 1);
      if (!ba) begin
        stall_left--;
        chk("stall_ramwe", bus_if.RAMWE, 0);
        chk("stall_next", bus_if.NextCA, 0);
        chk("stall_dma", bus_if.DMA, 1);
      end
      if (bus_if.RAMWE) begin
        ram_n++;
        if (q_ram.size() > 0) chk("ramdout", bus_if.RAMDOut, q_ram.pop_front());
      end
      if (bus_if.CDOE) begin
        cd_n++;
        if (q_cd.size() > 0) chk("cdout", bus_if.CDOut, q_cd.pop_front());
      end
      if (!bus_if.CRW) crw0_n++;
      chk("next_pair", bus_if.NextREUA, bus_if.NextCA);
      nxt = bus_if.NextCA;
      if (bus_if.XferEnd) begin
        end_n++;
        chk("verify_err", bus_if.VerifyErr, exp_verr);
        chk("end_dma", bus_if.DMA, 0);
      end else begin
        chk("dma_busy", bus_if.DMA, 1);
        chk("verr_quiet", bus_if.VerifyErr, 0);
      end
      @(negedge phi2);
      if (nxt) begin
        next_n++;
        ca++;
        rem--;
      end
    end
    bus_if.Execute = 1'b0;
    chk("busy_cycles", busy_n, exp_cycles);
    chk("next_count", next_n, exp_bytes);
    chk("xfer_end_count", end_n, 1);
    chk("ramwe_cycles", ram_n, exp_ram_n);
    chk("cdoe_cycles", cd_n, exp_cd_n);
    chk("crw0_cycles", crw0_n, exp_cd_n);
    chk("ram_q_left", q_ram.size(), 0);
    chk("cd_q_left", q_cd.size(), 0);
    q_ram.delete();
    q_cd.delete();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 8; i++) begin
      c_mem[i] = 8'h00;
      r_mem[i] = 8'h00;
    end
    reset           = 1'b1;
    bus_if.Execute  = 1'b0;
    bus_if.XferType = 2'b00;
    bus_if.Length1  = 1'b0;
    bus_if.BA       = 1'b1;
    bus_if.CDIn     = 8'h00;
    bus_if.RAMDIn   = 8'h00;
    #1;
    chk("rst_dma", bus_if.DMA, 0);
    chk("rst_crw", bus_if.CRW, 1);
    chk("rst_cdoe", bus_if.CDOE, 0);
    chk("rst_ramwe", bus_if.RAMWE, 0);
    chk("rst_busy", bus_if.Busy, 0);
    chk("rst_xferend", bus_if.XferEnd, 0);
    chk("rst_cdout", bus_if.CDOut, 0);
    chk("rst_ramdout", bus_if.RAMDOut, 0);
    repeat (2) @(posedge phi2);
    reset = 1'b0;

    // Stash of 3 bytes
    c_mem[0] = 8'hAA; c_mem[1] = 8'h55; c_mem[2] = 8'h0F;
    run_xfer(2'b00, 3, -1, 0, 3, 1'b0, 6);

    // Fetch of 2 bytes
    r_mem[0] = 8'h12; r_mem[1] = 8'h34;
    run_xfer(2'b01, 2, -1, 0, 2, 1'b0, 5);

    // Swap of 1 byte
    c_mem[0] = 8'h5A; r_mem[0] = 8'hA5;
    run_xfer(2'b10, 1, -1, 0, 1, 1'b0, 5);

    // Verify of 4 bytes, mismatch at the second byte
    c_mem[0] = 8'h11; c_mem[1] = 8'h22; c_mem[2] = 8'h33; c_mem[3] = 8'h44;
    r_mem[0] = 8'h11; r_mem[1] = 8'h2F; r_mem[2] = 8'h33; r_mem[3] = 8'h44;
    run_xfer(2'b11, 4, -1, 0, 2, 1'b1, 5);

    // Stash of 3 bytes with BA low for 3 cycles at the second byte
    c_mem[0] = 8'h01; c_mem[1] = 8'h82; c_mem[2] = 8'hC3;
    run_xfer(2'b00, 3, 1, 3, 3, 1'b0, 9);

    // Reset during the MOVE phase of a fetch
    @(posedge phi2);
    bus_if.Execute  = 1'b1;
    bus_if.XferType = 2'b01;
    bus_if.BA       = 1'b1;
    bus_if.Length1  = 1'b0;
    bus_if.RAMDIn   = 8'h77;
    @(negedge phi2);
    @(posedge phi2);
    bus_if.Execute = 1'b0;
    @(negedge phi2);
    @(posedge phi2);
    @(negedge phi2);
    @(posedge phi2);
    #2;
    chk("pre_rst_cdoe", bus_if.CDOE, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_dma", bus_if.DMA, 0);
    chk("async_rst_cdoe", bus_if.CDOE, 0);
    chk("async_rst_busy", bus_if.Busy, 0);
    @(negedge phi2);
    @(posedge phi2);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("post_rst_xferend", bus_if.XferEnd, 0);
      chk("post_rst_busy", bus_if.Busy, 0);
      @(posedge phi2);
    end

    // Single-byte stash after reset
    c_mem[0] = 8'hC3;
    run_xfer(2'b00, 1, -1, 0, 1, 1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
